// File: rtl/noc_pkg.sv
// Shared mesh-NoC definitions: header bit offsets (bit 0 is the packet MSB),
// hop-field width, output-port encodings and the default packet width.
package noc_pkg;

   localparam int NOC_PACKET_WIDTH = 64;

   localparam int HDR_VC      = 0;
   localparam int HDR_XDIR    = 1;
   localparam int HDR_YDIR    = 2;
   localparam int HDR_HOPX    = 8;
   localparam int HDR_HOPY    = 16;
   localparam int HDR_PAYLOAD = 32;
   localparam int HOP_W       = 8;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_EAST  = 3'd1,
      PORT_WEST  = 3'd2,
      PORT_NORTH = 3'd3,
      PORT_SOUTH = 3'd4
   } port_e;

endpackage

// File: rtl/vc_fifo.sv
// Per-VC packet FIFO: DEPTH entries (power of two), naturally wrapping
// pointers, occupancy count one bit wider than the pointers.
module vc_fifo
   import noc_pkg::*;
#(
   parameter int PACKET_WIDTH = NOC_PACKET_WIDTH,
   parameter int DEPTH        = 4,
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = AW + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [0:PACKET_WIDTH-1] push_data,
   input  logic                    pop,
   output logic [CW-1:0]           count,
   output logic [0:PACKET_WIDTH-1] head
);

   logic [0:PACKET_WIDTH-1] r_mem [DEPTH];
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;

   // Storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push) r_wptr <= r_wptr + AW'(1);
         if (pop)  r_rptr <= r_rptr + AW'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rptr];

endmodule

// File: rtl/router_input_channel.sv
// Router input channel: si/ri receive, VC steering into two FIFOs, X-first
// look-ahead route with hop decrement. Optional counters: ROUTER_IN_STATS_EN.
module router_input_channel
   import noc_pkg::*;
#(
   parameter int PACKET_WIDTH = NOC_PACKET_WIDTH,
   parameter int DEPTH        = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    polarity,
   input  logic                    si,
   output logic                    ri,
   input  logic [0:PACKET_WIDTH-1] di,
   output logic                    out_valid,
   output logic [0:PACKET_WIDTH-1] out_data,
   output logic [2:0]              out_req,
   input  logic                    out_grant,
   output logic                    drop_err
`ifdef ROUTER_IN_STATS_EN
   ,
   output logic [15:0]             stat_accept,
   output logic [15:0]             stat_drop
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0]           w_cnt0, w_cnt1, w_cnt_ext, w_cnt_int;
   logic [0:PACKET_WIDTH-1] w_head0, w_head1, w_head;
   logic [HOP_W-1:0]        w_hop_x, w_hop_y;
   logic                    w_xfer, w_acc, w_drop, w_pop;
   logic                    r_drop_err;

   // External VC (link side) is FIFO[polarity]; internal VC is FIFO[~polarity].
   assign w_cnt_ext = polarity ? w_cnt1 : w_cnt0;
   assign w_cnt_int = polarity ? w_cnt0 : w_cnt1;
   assign w_head    = polarity ? w_head0 : w_head1;

   assign ri        = reset && (w_cnt_ext != FULL);
   assign w_xfer    = si && ri;
   assign w_acc     = w_xfer && (di[HDR_VC] == polarity);
   assign w_drop    = w_xfer && (di[HDR_VC] != polarity);
   assign out_valid = (w_cnt_int != '0);
   assign w_pop     = out_grant && out_valid;

   vc_fifo #(.PACKET_WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_fifo_vc0 (
      .clk       (clk),
      .rst_n     (reset),
      .push      (w_acc && !polarity),
      .push_data (di),
      .pop       (w_pop && polarity),
      .count     (w_cnt0),
      .head      (w_head0)
   );

   vc_fifo #(.PACKET_WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_fifo_vc1 (
      .clk       (clk),
      .rst_n     (reset),
      .push      (w_acc && polarity),
      .push_data (di),
      .pop       (w_pop && !polarity),
      .count     (w_cnt1),
      .head      (w_head1)
   );

   assign w_hop_x = w_head[HDR_HOPX +: HOP_W];
   assign w_hop_y = w_head[HDR_HOPY +: HOP_W];

   // Outputs are forced to zero/LOCAL when empty so stale storage never leaks.
   always_comb begin
      out_data = '0;
      out_req  = PORT_LOCAL;
      if (out_valid) begin
         out_data = w_head;
         if (w_hop_x != '0) begin
            out_req = w_head[HDR_XDIR] ? PORT_WEST : PORT_EAST;
            out_data[HDR_HOPX +: HOP_W] = w_hop_x - HOP_W'(1);
         end else if (w_hop_y != '0) begin
            out_req = w_head[HDR_YDIR] ? PORT_SOUTH : PORT_NORTH;
            out_data[HDR_HOPY +: HOP_W] = w_hop_y - HOP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_drop_err <= 1'b0;
      else        r_drop_err <= w_drop;
   end

   assign drop_err = r_drop_err;

`ifdef ROUTER_IN_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] r_stat_accept;
   logic [15:0] r_stat_drop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_accept <= '0;
         r_stat_drop   <= '0;
      end else begin
         if (w_acc)  r_stat_accept <= sat_inc(r_stat_accept);
         if (w_drop) r_stat_drop   <= sat_inc(r_stat_drop);
      end
   end

   assign stat_accept = r_stat_accept;
   assign stat_drop   = r_stat_drop;
`endif

endmodule

// File: tb/tb_router_input_channel.sv
// Self-checking bench for router_input_channel: reset, directed vector table,
// full-FIFO and mid-stream reset sequences, then randomized model comparison.
module tb_router_input_channel;
   import noc_pkg::*;

   localparam int PW    = 64;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset, polarity, si, out_grant;
   logic          ri, out_valid, drop_err;
   logic [0:PW-1] di, out_data;
   logic [2:0]    out_req;
`ifdef ROUTER_IN_STATS_EN
   logic [15:0]   stat_accept, stat_drop;
`endif

   always #5 clk = ~clk;

   router_input_channel #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .polarity  (polarity),
      .si        (si),
      .ri        (ri),
      .di        (di),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_req   (out_req),
      .out_grant (out_grant),
      .drop_err  (drop_err)
`ifdef ROUTER_IN_STATS_EN
      ,
      .stat_accept (stat_accept),
      .stat_drop   (stat_drop)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [0:PW-1] mk(input logic vc, input logic xd, input logic yd,
                                        input logic [7:0] hx, input logic [7:0] hy,
                                        input logic [31:0] pay);
      logic [0:PW-1] p;
      p          = '0;
      p[0]       = vc;
      p[1]       = xd;
      p[2]       = yd;
      p[8 +: 8]  = hx;
      p[16 +: 8] = hy;
      p[32 +: 32] = pay;
      return p;
   endfunction

   // Reference routing: X first, then Y, else local; the non-zero hop field is reduced by one.
   task automatic ref_route(input logic [0:PW-1] p, output logic [2:0] req, output logic [0:PW-1] d);
      int hx, hy;
      hx = int'(p[8 +: 8]);
      hy = int'(p[16 +: 8]);
      d  = p;
      if (hx > 0) begin
         req = p[1] ? 3'd2 : 3'd1;
         d[8 +: 8] = 8'(hx - 1);
      end else if (hy > 0) begin
         req = p[2] ? 3'd4 : 3'd3;
         d[16 +: 8] = 8'(hy - 1);
      end else begin
         req = 3'd0;
      end
   endtask

   typedef struct {
      logic          pol, s, g;
      logic [0:PW-1] d;
      logic          e_ri, e_valid;
      logic [2:0]    e_req;
      logic [0:PW-1] e_data;
      logic          e_drop;
   } vec_t;

   vec_t tbl[12];

   logic [0:PW-1] q[2][$];
   logic [0:PW-1] hd, exp_d;
   logic [2:0]    exp_r;
   logic          exp_drop, nxt_drop, exp_ri, exp_valid, vc;

   initial begin
      reset = 1'b0; polarity = 1'b0; si = 1'b0; out_grant = 1'b0; di = '0;

      // Reset held low for three cycles
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_ri", ri, 0);
         chk("rst_valid", out_valid, 0);
      end
      chk("rst_req", out_req, 0);
      chk("rst_data", out_data, 0);
      chk("rst_drop", drop_err, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rel_ri", ri, 1);
      chk("rel_valid", out_valid, 0);
      chk("rel_req", out_req, 0);

      tbl[0]  = '{0, 1, 0, mk(0,0,0,2,1,32'hA0), 1, 0, 0, '0, 0};
      tbl[1]  = '{1, 0, 1, '0, 1, 1, 1, mk(0,0,0,1,1,32'hA0), 0};
      tbl[2]  = '{0, 1, 0, mk(0,0,1,0,0,32'hB1), 1, 0, 0, '0, 0};
      tbl[3]  = '{1, 1, 1, mk(1,0,1,0,3,32'hC2), 1, 1, 0, mk(0,0,1,0,0,32'hB1), 0};
      tbl[4]  = '{0, 0, 1, '0, 1, 1, 4, mk(1,0,1,0,2,32'hC2), 0};
      tbl[5]  = '{1, 0, 0, '0, 1, 0, 0, '0, 0};
      tbl[6]  = '{0, 1, 0, mk(0,1,0,1,7,32'hD3), 1, 0, 0, '0, 0};
      tbl[7]  = '{1, 1, 1, mk(1,0,0,0,1,32'hE4), 1, 1, 2, mk(0,1,0,0,7,32'hD3), 0};
      tbl[8]  = '{0, 0, 1, '0, 1, 1, 3, mk(1,0,0,0,0,32'hE4), 0};
      tbl[9]  = '{0, 1, 0, mk(1,0,0,1,1,32'hF5), 1, 0, 0, '0, 0};
      tbl[10] = '{0, 0, 0, '0, 1, 0, 0, '0, 1};
      tbl[11] = '{1, 0, 1, '0, 1, 0, 0, '0, 0};

      for (int i = 0; i < 12; i++) begin
         polarity = tbl[i].pol; si = tbl[i].s; out_grant = tbl[i].g; di = tbl[i].d;
         #1;
         chk($sformatf("vec%0d_ri", i), ri, tbl[i].e_ri);
         chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d_drop", i), drop_err, tbl[i].e_drop);
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d_req", i), out_req, tbl[i].e_req);
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
         end
         @(posedge clk); #1;
      end
      si = 1'b0; out_grant = 1'b0;
`ifdef ROUTER_IN_STATS_EN
      chk("stat_accept", stat_accept, 5);
      chk("stat_drop", stat_drop, 1);
`endif

      // Fill VC1 while it is external: ri drops after four, fifth held without drop
      polarity = 1'b1;
      for (int k = 0; k < 5; k++) begin
         si = 1'b1; di = mk(1, 0, 0, 0, 0, 32'(k));
         #1;
         chk($sformatf("full%0d_ri", k), ri, (k < 4));
         chk($sformatf("full%0d_drop", k), drop_err, 0);
         @(posedge clk); #1;
      end
      chk("full_held_drop", drop_err, 0);
      si = 1'b0;
      polarity = 1'b0; #1;
      chk("full_vc1_valid", out_valid, 1);
      chk("full_vc1_head", out_data, mk(1, 0, 0, 0, 0, 32'd0));

      // Two packets into VC0, then a one-cycle reset mid-stream
      si = 1'b1;
      for (int k = 0; k < 2; k++) begin
         di = mk(0, 0, 0, 0, 1, 32'h50 + 32'(k));
         #1;
         chk("mid_push_ri", ri, 1);
         @(posedge clk); #1;
      end
      si = 1'b0; polarity = 1'b1; #1;
      chk("mid_vc0_valid", out_valid, 1);
      chk("mid_vc0_req", out_req, 3);
      reset = 1'b0; #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ri", ri, 0);
      polarity = 1'b0; #1;
      chk("mid_rst_valid_vc1", out_valid, 0);
      @(posedge clk); #1;
      reset = 1'b1; @(posedge clk); #1;
      chk("post_ri0", ri, 1);
      chk("post_valid0", out_valid, 0);
      polarity = 1'b1; #1;
      chk("post_ri1", ri, 1);
      chk("post_valid1", out_valid, 0);

      // Randomized run against the queue model, from a clean reset
      reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
      q[0].delete(); q[1].delete();
      exp_drop = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) != 0) polarity = ~polarity;
         si        = 1'($urandom_range(0, 1));
         out_grant = 1'($urandom_range(0, 2) == 0);
         vc        = ($urandom_range(0, 3) == 0) ? ~polarity : polarity;
         di        = mk(vc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), $urandom);
         #1;
         exp_ri    = (q[polarity].size() != DEPTH);
         exp_valid = (q[!polarity].size() != 0);
         chk("rnd_ri", ri, exp_ri);
         chk("rnd_valid", out_valid, exp_valid);
         chk("rnd_drop", drop_err, exp_drop);
         if (exp_valid) begin
            hd = q[!polarity][0];
            ref_route(hd, exp_r, exp_d);
            chk("rnd_req", out_req, exp_r);
            chk("rnd_data", out_data, exp_d);
         end
         nxt_drop = 1'b0;
         if (si && exp_ri) begin
            if (vc == polarity) q[polarity].push_back(di);
            else                nxt_drop = 1'b1;
         end
         if (out_grant && exp_valid) void'(q[!polarity].pop_front());
         exp_drop = nxt_drop;
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
